// File: rtl/viterbi_pkg.sv
// Shared types and constants for the viterbi front end: softbit word geometry,
// loader state encoding and the coded-bits-per-symbol clamp.
package viterbi_pkg;

    localparam int SB_W      = 4;
    localparam int SB_LANES  = 6;
    localparam int SB_WORD_W = SB_W * SB_LANES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_KICK = 2'd2,
        ST_WAIT = 2'd3
    } loader_state_t;

    // Legal symbol widths are 2..6; anything outside is pulled to the nearest edge.
    function automatic logic [2:0] clamp_poly(input logic [2:0] poly);
        if (poly < 3'd2) begin
            return 3'd2;
        end else if (poly > 3'd6) begin
            return 3'd6;
        end
        return poly;
    endfunction

endpackage

// File: rtl/softbit_quant.sv
// 8-bit soft value to 4-bit lane value. SOFTBIT_SAT_EN selects shift+saturate,
// otherwise the value is truncated to its low nibble.
module softbit_quant
    import viterbi_pkg::*;
(
    input  logic [7:0]      data,
    input  logic [1:0]      shift,
    output logic [SB_W-1:0] quant
);

`ifdef SOFTBIT_SAT_EN
    logic signed [7:0] shifted;

    assign shifted = $signed(data) >>> shift;

    always_comb begin
        if (shifted > 8'sd7) begin
            quant = 4'h7;
        end else if (shifted < -8'sd8) begin
            quant = 4'h8;
        end else begin
            quant = shifted[SB_W-1:0];
        end
    end
`else
    // Upper bits and shift only matter when saturating; the zero mask keeps them read.
    assign quant = data[SB_W-1:0] | {SB_W{1'b0 & (^{shift, data[7:SB_W]})}};
`endif

endmodule

// File: rtl/softbit_loader.sv
// Packs a stream of soft values into 24-bit trellis words, writes them to the input
// softbit SRAM and then hands the frame to viterbi_core. Optional macro: SOFTBIT_SAT_EN.
module softbit_loader
    import viterbi_pkg::*;
#(
    parameter int SRC_ADDR_W = 12,
    parameter int LEN_W      = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_an_i,
    input  logic                  rst_sync_i,
    input  logic                  load_start_i,
    input  logic [2:0]            poly_num_i,
    input  logic [LEN_W-1:0]      infobit_length_i,
    input  logic [SRC_ADDR_W-1:0] src_start_addr_i,
    input  logic                  sb_valid_i,
    input  logic [7:0]            sb_data_i,
    output logic                  sb_ready_o,
    input  logic [1:0]            sat_shift_i,
    output logic                  mem_wr_o,
    output logic [SRC_ADDR_W-1:0] mem_addr_o,
    output logic [SB_WORD_W-1:0]  mem_wdata_o,
    output logic                  frame_start_o,
    input  logic                  frame_done_i,
    output logic                  busy_o,
    output logic                  done_o
);

    loader_state_t         state_reg, state_next;
    logic [2:0]            n_reg;
    logic [2:0]            lane_cnt_reg;
    logic [LEN_W-1:0]      len_reg;
    logic [LEN_W-1:0]      word_cnt_reg;
    logic [SRC_ADDR_W-1:0] start_reg;
    logic [SRC_ADDR_W-1:0] addr_reg;
    logic [SB_WORD_W-1:0]  wdata_reg;
    logic [SB_WORD_W-1:0]  word_next;
    logic [SB_W-1:0]       lane_reg [SB_LANES];
    logic                  wr_reg;
    logic                  last_pending_reg;
    logic                  done_reg;
    logic [SB_W-1:0]       quant;
    logic                  handshake;
    logic                  word_complete;
    logic                  last_word;
    logic                  load_accept;

    softbit_quant u_quant (
        .data  (sb_data_i),
        .shift (sat_shift_i),
        .quant (quant)
    );

    assign sb_ready_o    = (state_reg == ST_LOAD) & ~last_pending_reg;
    assign handshake     = sb_valid_i & sb_ready_o;
    assign word_complete = handshake && (lane_cnt_reg == n_reg - 3'd1);
    assign last_word     = word_complete && (word_cnt_reg == len_reg - LEN_W'(1));
    assign load_accept   = (state_reg == ST_IDLE) && load_start_i;

    // The value completing a word is folded in directly so the write lands one cycle later.
    for (genvar gi = 0; gi < SB_LANES; gi++) begin : g_pack
        assign word_next[gi*SB_W +: SB_W] = (3'(gi) >= n_reg)        ? '0    :
                                            (3'(gi) == lane_cnt_reg) ? quant :
                                                                       lane_reg[gi];
    end

    always_comb begin
        state_next    = state_reg;
        frame_start_o = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (load_start_i && (infobit_length_i != '0)) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (last_pending_reg) begin
                    state_next = ST_KICK;
                end
            end
            ST_KICK: begin
                frame_start_o = 1'b1;
                state_next    = ST_WAIT;
            end
            ST_WAIT: begin
                if (frame_done_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            state_reg        <= ST_IDLE;
            n_reg            <= 3'd2;
            lane_cnt_reg     <= '0;
            len_reg          <= '0;
            word_cnt_reg     <= '0;
            start_reg        <= '0;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            wr_reg           <= 1'b0;
            last_pending_reg <= 1'b0;
            done_reg         <= 1'b0;
            for (int i = 0; i < SB_LANES; i++) begin
                lane_reg[i] <= '0;
            end
        end else if (rst_sync_i) begin
            state_reg        <= ST_IDLE;
            n_reg            <= 3'd2;
            lane_cnt_reg     <= '0;
            len_reg          <= '0;
            word_cnt_reg     <= '0;
            start_reg        <= '0;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            wr_reg           <= 1'b0;
            last_pending_reg <= 1'b0;
            done_reg         <= 1'b0;
            for (int i = 0; i < SB_LANES; i++) begin
                lane_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            wr_reg    <= 1'b0;
            done_reg  <= (state_reg == ST_WAIT) && frame_done_i;

            if (load_accept) begin
                n_reg            <= clamp_poly(poly_num_i);
                len_reg          <= infobit_length_i;
                start_reg        <= src_start_addr_i;
                lane_cnt_reg     <= '0;
                word_cnt_reg     <= '0;
                last_pending_reg <= 1'b0;
                // An empty frame completes on the spot without touching the core.
                done_reg         <= (infobit_length_i == '0);
                for (int i = 0; i < SB_LANES; i++) begin
                    lane_reg[i] <= '0;
                end
            end

            if (handshake) begin
                lane_reg[lane_cnt_reg] <= quant;
                if (word_complete) begin
                    lane_cnt_reg <= '0;
                    wr_reg       <= 1'b1;
                    wdata_reg    <= word_next;
                    addr_reg     <= start_reg + SRC_ADDR_W'(word_cnt_reg);
                    word_cnt_reg <= word_cnt_reg + LEN_W'(1);
                    if (last_word) begin
                        last_pending_reg <= 1'b1;
                    end
                end else begin
                    lane_cnt_reg <= lane_cnt_reg + 3'd1;
                end
            end
        end
    end

    assign mem_wr_o    = wr_reg;
    assign mem_addr_o  = addr_reg;
    assign mem_wdata_o = wdata_reg;
    assign busy_o      = (state_reg != ST_IDLE);
    assign done_o      = done_reg;

endmodule

// File: tb/tb_softbit_loader.sv
// Randomized bench for softbit_loader: a word-level model built from accepted soft
// values predicts every SRAM write; literal expectations pin the directed cases.
module tb_softbit_loader;

    logic        clk = 1'b0;
    logic        rst_an_i, rst_sync_i, load_start_i;
    logic [2:0]  poly_num_i;
    logic [11:0] infobit_length_i, src_start_addr_i;
    logic        sb_valid_i;
    logic [7:0]  sb_data_i;
    logic        sb_ready_o;
    logic [1:0]  sat_shift_i;
    logic        mem_wr_o;
    logic [11:0] mem_addr_o;
    logic [23:0] mem_wdata_o;
    logic        frame_start_o, frame_done_i, busy_o, done_o;

    always #5 clk = ~clk;

    softbit_loader #(.SRC_ADDR_W(12), .LEN_W(12)) dut (
        .clk_i            (clk),
        .rst_an_i         (rst_an_i),
        .rst_sync_i       (rst_sync_i),
        .load_start_i     (load_start_i),
        .poly_num_i       (poly_num_i),
        .infobit_length_i (infobit_length_i),
        .src_start_addr_i (src_start_addr_i),
        .sb_valid_i       (sb_valid_i),
        .sb_data_i        (sb_data_i),
        .sb_ready_o       (sb_ready_o),
        .sat_shift_i      (sat_shift_i),
        .mem_wr_o         (mem_wr_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .frame_start_o    (frame_start_o),
        .frame_done_i     (frame_done_i),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    // ---------------- behavioural model ----------------
    logic [23:0] exp_data_q[$];
    logic [11:0] exp_addr_q[$];
    logic [23:0] cap_data[$];
    logic [11:0] cap_addr[$];
    logic [11:0] held_addr = '0;
    logic [23:0] held_data = '0;
    int model_n, model_words, model_lane, model_acc;
    logic [11:0] model_start;
    int fs_cnt = 0, done_cnt = 0, wr_cnt = 0;
    bit mon_en = 1'b0;

    function automatic int quant_model(input logic [7:0] v, input int sh);
`ifdef SOFTBIT_SAT_EN
        int x;
        x = int'($signed(v));
        x = x >>> sh;
        if (x > 7) x = 7;
        if (x < -8) x = -8;
        return x & 15;
`else
        return int'(v) % 16;
`endif
    endfunction

    task automatic model_accept(input logic [7:0] v);
        model_acc += quant_model(v, int'(sat_shift_i)) << (4 * model_lane);
        model_lane++;
        if (model_lane == model_n) begin
            exp_data_q.push_back(24'(model_acc));
            exp_addr_q.push_back(12'((int'(model_start) + model_words) % 4096));
            model_words++;
            model_lane = 0;
            model_acc  = 0;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_wr_o) begin
                wr_cnt++;
                cap_data.push_back(mem_wdata_o);
                cap_addr.push_back(mem_addr_o);
                if (exp_data_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_write: got write addr %0h data %0h, required no write",
                             mem_addr_o, mem_wdata_o);
                end else begin
                    held_addr = exp_addr_q.pop_front();
                    held_data = exp_data_q.pop_front();
                    check("wr_addr", 32'(mem_addr_o), 32'(held_addr));
                    check("wr_data", 32'(mem_wdata_o), 32'(held_data));
                end
            end else begin
                check("hold_addr", 32'(mem_addr_o), 32'(held_addr));
                check("hold_data", 32'(mem_wdata_o), 32'(held_data));
            end
            if (sb_ready_o && !busy_o) check("ready_while_idle", 32'(sb_ready_o), 32'd0);
            if (frame_start_o) fs_cnt++;
            if (done_o) done_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_frame(input logic [2:0] poly, input int len, input logic [11:0] start);
        model_n     = (poly < 2) ? 2 : (poly > 6) ? 6 : int'(poly);
        model_start = start;
        model_words = 0;
        model_lane  = 0;
        model_acc   = 0;
        cap_data.delete();
        cap_addr.delete();
        poly_num_i       = poly;
        infobit_length_i = 12'(len);
        src_start_addr_i = start;
        load_start_i     = 1'b1;
        @(posedge clk); #1;
        load_start_i     = 1'b0;
        poly_num_i       = 3'($urandom);
        infobit_length_i = 12'($urandom);
        src_start_addr_i = 12'($urandom);
    endtask

    task automatic send(input logic [7:0] vals[$], input bit gaps, output int cycles);
        int idx = 0;
        cycles = 0;
        while (idx < vals.size()) begin
            sb_valid_i = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            sb_data_i  = sb_valid_i ? vals[idx] : 8'($urandom);
            if (gaps) begin
                // stray controls while loading must be ignored
                load_start_i = ($urandom_range(0, 3) == 0);
                frame_done_i = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            if (sb_valid_i && sb_ready_o) begin
                model_accept(vals[idx]);
                idx++;
            end
            @(posedge clk); #1;
            cycles++;
            if (cycles > 4 * vals.size() + 100) begin
                total_cnt++;
                $display("FAIL send_timeout: got %0d values accepted, required %0d", idx, vals.size());
                break;
            end
        end
        sb_valid_i   = 1'b0;
        load_start_i = 1'b0;
        frame_done_i = 1'b0;
    endtask

    task automatic finish_frame();
        int fs0 = fs_cnt;
        int d0  = done_cnt;
        int seen_at = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (frame_start_o) begin seen_at = i; break; end
        end
        check("kick_latency", 32'(seen_at), 32'd1);
        check("all_words_written", 32'(exp_data_q.size()), 32'd0);
        @(posedge clk); #1;
        repeat ($urandom_range(1, 5)) begin
            @(negedge clk);
            check("busy_in_wait", 32'(busy_o), 32'd1);
            @(posedge clk); #1;
        end
        frame_done_i = 1'b1;
        @(posedge clk); #1;
        frame_done_i = 1'b0;
        @(negedge clk);
        check("done_pulse", 32'(done_o), 32'd1);
        check("busy_after_done", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("done_single", 32'(done_o), 32'd0);
        check("frame_start_count", 32'(fs_cnt - fs0), 32'd1);
        check("done_count", 32'(done_cnt - d0), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input logic [2:0] poly, input int len, input logic [11:0] start,
                             input logic [7:0] vals[$], input bit gaps, output int cycles);
        start_frame(poly, len, start);
        send(vals, gaps, cycles);
        finish_frame();
    endtask

    function automatic int clamp_n(input logic [2:0] p);
        return (p < 2) ? 2 : (p > 6) ? 6 : int'(p);
    endfunction

    initial begin
        logic [7:0]  vals[$];
        logic [23:0] ref_words[$];
        int cycles, fs0, d0, w0, n;
        logic [11:0] st;

        rst_an_i = 1'b0; rst_sync_i = 1'b0; load_start_i = 1'b0; poly_num_i = '0;
        infobit_length_i = '0; src_start_addr_i = '0; sb_valid_i = 1'b0; sb_data_i = '0;
        sat_shift_i = '0; frame_done_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_wr", 32'(mem_wr_o), 32'd0);
        check("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata_o), 32'd0);
        check("rst_frame_start", 32'(frame_start_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_ready", 32'(sb_ready_o), 32'd0);
        @(posedge clk); #1;
        rst_an_i = 1'b1;
        mon_en   = 1'b1;
        @(posedge clk); #1;

        // 1: N=2, 192 words at full rate
        vals.delete();
        for (int i = 0; i < 2 * 192; i++) vals.push_back((i % 2 == 0) ? 8'h03 : 8'hFE);
        w0 = wr_cnt;
        run_frame(3'd2, 192, 12'h000, vals, 1'b0, cycles);
        check("t1_full_rate_cycles", 32'(cycles), 32'd384);
        check("t1_write_count", 32'(wr_cnt - w0), 32'd192);
        check("t1_first_word", 32'(cap_data[0]), 32'h0000E3);
        check("t1_last_word", 32'(cap_data[191]), 32'h0000E3);
        check("t1_last_addr", 32'(cap_addr[191]), 32'h0BF);

        // 2: N=6, two words from 1..12
        vals.delete();
        for (int i = 1; i <= 12; i++) vals.push_back(8'(i));
        run_frame(3'd6, 2, 12'h123, vals, 1'b0, cycles);
        check("t2_word0", 32'(cap_data[0]), 32'h654321);
`ifdef SOFTBIT_SAT_EN
        check("t2_word1", 32'(cap_data[1]), 32'h777777);
`else
        check("t2_word1", 32'(cap_data[1]), 32'hCBA987);
`endif
        check("t2_addr1", 32'(cap_addr[1]), 32'h124);

        // 3: address wrap
        vals.delete();
        for (int i = 0; i < 6; i++) vals.push_back(8'($urandom));
        run_frame(3'd2, 3, 12'hFFF, vals, 1'b0, cycles);
        check("t3_addr0", 32'(cap_addr[0]), 32'hFFF);
        check("t3_addr1", 32'(cap_addr[1]), 32'h000);
        check("t3_addr2", 32'(cap_addr[2]), 32'h001);

        // 4: same stream with gaps and stray controls must give identical words
        vals.delete();
        for (int i = 0; i < 4 * 5; i++) vals.push_back(8'($urandom));
        run_frame(3'd4, 5, 12'h300, vals, 1'b0, cycles);
        ref_words = cap_data;
        run_frame(3'd4, 5, 12'h300, vals, 1'b1, cycles);
        for (int i = 0; i < 5; i++) check("t4_gap_vs_full", 32'(cap_data[i]), 32'(ref_words[i]));

        // 5: quantizer corners
        sat_shift_i = 2'd1;
        vals.delete();
        vals.push_back(8'h7F); vals.push_back(8'h80); vals.push_back(8'h06);
        run_frame(3'd3, 1, 12'h010, vals, 1'b0, cycles);
`ifdef SOFTBIT_SAT_EN
        check("t5_quant_word", 32'(cap_data[0]), 32'h000387);
`else
        check("t5_quant_word", 32'(cap_data[0]), 32'h00060F);
`endif
        sat_shift_i = 2'd0;

        // zero-length frame: done next cycle, nothing else
        fs0 = fs_cnt; w0 = wr_cnt;
        start_frame(3'd3, 0, 12'h055);
        @(negedge clk);
        check("len0_done", 32'(done_o), 32'd1);
        check("len0_busy", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        repeat (4) begin @(negedge clk); @(posedge clk); #1; end
        check("len0_no_start", 32'(fs_cnt - fs0), 32'd0);
        check("len0_no_write", 32'(wr_cnt - w0), 32'd0);

        // 6: sync abort after 5 of 10 words
        n  = clamp_n(3'd5);
        st = 12'h7A0;
        fs0 = fs_cnt; d0 = done_cnt; w0 = wr_cnt;
        start_frame(3'd5, 10, st);
        vals.delete();
        for (int i = 0; i < 5 * n; i++) vals.push_back(8'($urandom));
        send(vals, 1'b0, cycles);
        rst_sync_i = 1'b1;
        @(posedge clk); #1;
        rst_sync_i = 1'b0;
        held_addr  = '0;
        held_data  = '0;
        repeat (20) begin
            @(negedge clk);
            check("t6_idle_after_abort", 32'(busy_o), 32'd0);
            @(posedge clk); #1;
        end
        check("t6_writes", 32'(wr_cnt - w0), 32'd5);
        check("t6_no_start", 32'(fs_cnt - fs0), 32'd0);
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);
        vals.delete();
        for (int i = 0; i < 2 * n; i++) vals.push_back(8'($urandom));
        run_frame(3'd5, 2, st, vals, 1'b0, cycles);
        check("t6_restart_addr", 32'(cap_addr[0]), 32'(st));

        // random frames, including out-of-range poly values
        for (int f = 0; f < 8; f++) begin
            logic [2:0] p;
            int len;
            p   = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 7);
            sat_shift_i = 2'($urandom);
            vals.delete();
            for (int i = 0; i < len * clamp_n(p); i++) vals.push_back(8'($urandom));
            run_frame(p, len, 12'($urandom), vals, 1'($urandom_range(0, 1)), cycles);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
